id_stage: RTL and testbench

Instruction decode and operand fetch stage, directly upstream of the integer ALU. Accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake, decodes the OP (0110011) and OP-IMM (0010011) classes, and reads rs1/rs2 from an internal 32-entry register file. It presents opcode, funct fields, operands and immediate to the ALU from a single registered output slot. The writeback port updates the register file.

---
 rtl/id_stage.sv | 218 +++++++++++++++++++++
 tb/tb_id_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : RV32I decode / operand-fetch stage feeding the integer ALU.
//
// Accepts one instruction per cycle over a valid/ready handshake, decodes the
// OP and OP-IMM classes, reads rs1/rs2 from an internal 32-entry register file
// and presents the result from a single registered output slot.
//
// Optional feature macro: ID_STAGE_BYPASS_EN
//   defined     : a same-edge writeback forwards into the operands being
//                 captured, and refreshes the operands of a stalled slot.
//   not defined : operands come from pre-write register-file contents and
//                 held operands never change.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clk_en                state-update enable (everything frozen when low)
//   i_if_valid/o_if_ready instruction handshake from fetch
//   i_if_instr            32-bit instruction word
//   o_ex_valid/i_ex_ready output-slot handshake to the ALU
//   o_opcode .. o_illegal decoded fields and operands of the held slot
//   i_wb_we/addr/data     register-file writeback port
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_if_valid,
    output logic                  o_if_ready,
    input  logic [31:0]           i_if_instr,
    output logic                  o_ex_valid,
    input  logic                  i_ex_ready,
    output logic [6:0]            o_opcode,
    output logic [6:0]            o_funct7,
    output logic [2:0]            o_funct3,
    output logic [DATA_WIDTH:0]   o_rs1_data,
    output logic [DATA_WIDTH:0]   o_rs2_data,
    output logic [31:0]           o_imm,
    output logic [4:0]            o_rd_addr,
    output logic                  o_rd_we,
    output logic                  o_illegal,
    input  logic                  i_wb_we,
    input  logic [4:0]            i_wb_addr,
    input  logic [DATA_WIDTH:0]   i_wb_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    function automatic logic [31:0] sext_i12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic [31:0] zext_shamt(input logic [4:0] v);
        return {27'b0, v};
    endfunction

    // ---------------- stage p0: field extraction, decode, operand read ------
    logic [6:0] ins_opcode;
    logic [4:0] ins_rd;
    logic [2:0] ins_funct3;
    logic [4:0] ins_rs1;
    logic [4:0] ins_rs2;
    logic [6:0] ins_funct7;

    assign ins_opcode = i_if_instr[6:0];
    assign ins_rd     = i_if_instr[11:7];
    assign ins_funct3 = i_if_instr[14:12];
    assign ins_rs1    = i_if_instr[19:15];
    assign ins_rs2    = i_if_instr[24:20];
    assign ins_funct7 = i_if_instr[31:25];

    logic        vld_p1;
    logic        accept;
    logic        consume;
    logic        wb_fire;

    assign o_if_ready = clk_en & (~vld_p1 | i_ex_ready);
    assign accept     = i_if_valid & o_if_ready;
    assign consume    = clk_en & vld_p1 & i_ex_ready;
    assign wb_fire    = clk_en & i_wb_we;

    logic        legal_p0;
    logic [6:0]  funct7_p0;
    logic [31:0] imm_p0;
    logic        use_rs2_p0;

    always_comb begin
        legal_p0   = 1'b0;
        funct7_p0  = ins_funct7;
        imm_p0     = '0;
        use_rs2_p0 = 1'b1;
        if (ins_opcode == OPC_OP) begin
            legal_p0 = (ins_funct7 == F7_BASE) ||
                       ((ins_funct7 == F7_ALT) &&
                        ((ins_funct3 == 3'b000) || (ins_funct3 == 3'b101)));
        end else if (ins_opcode == OPC_OP_IMM) begin
            use_rs2_p0 = 1'b0;
            if (ins_funct3 == 3'b001) begin
                imm_p0   = zext_shamt(ins_rs2);
                legal_p0 = (ins_funct7 == F7_BASE);
            end else if (ins_funct3 == 3'b101) begin
                imm_p0   = zext_shamt(ins_rs2);
                legal_p0 = (ins_funct7 == F7_BASE) || (ins_funct7 == F7_ALT);
            end else begin
                imm_p0    = sext_i12(i_if_instr[31:20]);
                funct7_p0 = '0;
                legal_p0  = 1'b1;
            end
        end
    end

    logic [DATA_WIDTH:0] rf_mem [32];
    logic [DATA_WIDTH:0] rs1_data_p0;
    logic [DATA_WIDTH:0] rs2_data_p0;

    always_comb begin
        rs1_data_p0 = (ins_rs1 == 5'd0) ? '0 : rf_mem[ins_rs1];
        rs2_data_p0 = (ins_rs2 == 5'd0) ? '0 : rf_mem[ins_rs2];
`ifdef ID_STAGE_BYPASS_EN
        // Forward a writeback landing on the same edge as the capture.
        if (wb_fire && (i_wb_addr != 5'd0) && (i_wb_addr == ins_rs1))
            rs1_data_p0 = i_wb_data;
        if (wb_fire && (i_wb_addr != 5'd0) && (i_wb_addr == ins_rs2))
            rs2_data_p0 = i_wb_data;
`endif
        if (!use_rs2_p0)
            rs2_data_p0 = '0;
    end

    // x0 is never written, so its entry stays zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] <= '0;
        end else if (wb_fire && (i_wb_addr != 5'd0)) begin
            rf_mem[i_wb_addr] <= i_wb_data;
        end
    end

    // ---------------- stage p1: output slot ---------------------------------
    logic [6:0]          opcode_p1;
    logic [6:0]          funct7_p1;
    logic [2:0]          funct3_p1;
    logic [DATA_WIDTH:0] rs1_data_p1;
    logic [DATA_WIDTH:0] rs2_data_p1;
    logic [31:0]         imm_p1;
    logic [4:0]          rd_addr_p1;
    logic                rd_we_p1;
    logic                illegal_p1;
`ifdef ID_STAGE_BYPASS_EN
    logic [4:0]          rs1_addr_p1;
    logic [4:0]          rs2_addr_p1;
    logic                opimm_p1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            opcode_p1   <= '0;
            funct7_p1   <= '0;
            funct3_p1   <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rd_addr_p1  <= '0;
            rd_we_p1    <= 1'b0;
            illegal_p1  <= 1'b0;
`ifdef ID_STAGE_BYPASS_EN
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            opimm_p1    <= 1'b0;
`endif
        end else if (accept) begin
            // Covers the simultaneous consume+accept case: slot simply reloads.
            vld_p1      <= 1'b1;
            opcode_p1   <= legal_p0 ? ins_opcode : 7'd0;
            funct7_p1   <= funct7_p0;
            funct3_p1   <= ins_funct3;
            rs1_data_p1 <= rs1_data_p0;
            rs2_data_p1 <= rs2_data_p0;
            imm_p1      <= imm_p0;
            rd_addr_p1  <= ins_rd;
            rd_we_p1    <= legal_p0 && (ins_rd != 5'd0);
            illegal_p1  <= ~legal_p0;
`ifdef ID_STAGE_BYPASS_EN
            rs1_addr_p1 <= ins_rs1;
            rs2_addr_p1 <= ins_rs2;
            opimm_p1    <= ~use_rs2_p0;
`endif
        end else if (consume) begin
            vld_p1 <= 1'b0;
`ifdef ID_STAGE_BYPASS_EN
        end else if (vld_p1 && wb_fire && (i_wb_addr != 5'd0)) begin
            // Stalled slot: keep held operands coherent with the register file.
            if (i_wb_addr == rs1_addr_p1)
                rs1_data_p1 <= i_wb_data;
            if (!opimm_p1 && (i_wb_addr == rs2_addr_p1))
                rs2_data_p1 <= i_wb_data;
`endif
        end
    end

    assign o_ex_valid = vld_p1;
    assign o_opcode   = opcode_p1;
    assign o_funct7   = funct7_p1;
    assign o_funct3   = funct3_p1;
    assign o_rs1_data = rs1_data_p1;
    assign o_rs2_data = rs2_data_p1;
    assign o_imm      = imm_p1;
    assign o_rd_addr  = rd_addr_p1;
    assign o_rd_we    = rd_we_p1;
    assign o_illegal  = illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage : randomized + directed bench for id_stage against a
// behavioural model of the decode rules, register file and output slot.
// Define ID_STAGE_BYPASS_EN for both files to exercise the bypass build.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b0;
    logic        i_if_valid = 1'b0;
    logic        o_if_ready;
    logic [31:0] i_if_instr = '0;
    logic        o_ex_valid;
    logic        i_ex_ready = 1'b0;
    logic [6:0]  o_opcode;
    logic [6:0]  o_funct7;
    logic [2:0]  o_funct3;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [31:0] o_imm;
    logic [4:0]  o_rd_addr;
    logic        o_rd_we;
    logic        o_illegal;
    logic        i_wb_we = 1'b0;
    logic [4:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;

    id_stage #(.DATA_WIDTH(31)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_instr(i_if_instr),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
        .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we), .o_illegal(o_illegal),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit        vld;
        bit        known;     // opcode is OP or OP-IMM, so every field is defined
        bit [6:0]  opc;
        bit [6:0]  f7;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] imm;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit        we;
        bit        ill;
        bit        opimm;
    } slot_t;

    slot_t     m;
    bit [31:0] mrf [32];
`ifdef ID_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic slot_t decode(input bit [31:0] ins);
        slot_t s;
        bit    legal;
        s = '0;
        s.f3 = ins[14:12]; s.rd = ins[11:7]; s.rs1 = ins[19:15]; s.rs2 = ins[24:20];
        s.f7 = ins[31:25]; s.known = 1'b1; legal = 1'b0;
        if (ins[6:0] == 7'h33) begin
            legal = (s.f7 == 7'h00) || (s.f7 == 7'h20 && (s.f3 == 3'd0 || s.f3 == 3'd5));
        end else if (ins[6:0] == 7'h13) begin
            s.opimm = 1'b1;
            if (s.f3 == 3'd1 || s.f3 == 3'd5) begin
                s.imm = 32'(ins[24:20]);
                legal = (s.f7 == 7'h00) || (s.f3 == 3'd5 && s.f7 == 7'h20);
            end else begin
                s.imm = 32'($signed(ins) >>> 20);
                s.f7  = 7'h00;
                legal = 1'b1;
            end
        end else begin
            s.known = 1'b0;
        end
        s.ill = !legal;
        s.opc = legal ? ins[6:0] : 7'h00;
        s.we  = legal && (s.rd != 5'd0);
        return s;
    endfunction

    function automatic bit [31:0] mread(input bit [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (BYP && clk_en && i_wb_we && i_wb_addr == r) return i_wb_data;
        return mrf[r];
    endfunction

    task automatic model_reset();
        m = '0;
        m.known = 1'b1;
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    endtask

    // Applied at each rising edge using the inputs that were stable before it.
    task automatic model_edge();
        slot_t n;
        bit    acc;
        if (!clk_en) return;
        acc = i_if_valid && (!m.vld || i_ex_ready);
        if (acc) begin
            n = decode(i_if_instr);
            n.vld = 1'b1;
            n.a = mread(n.rs1);
            n.b = n.opimm ? 32'h0 : mread(n.rs2);
            m = n;
        end else if (m.vld && i_ex_ready) begin
            m.vld = 1'b0;
        end else if (BYP && m.vld && i_wb_we && i_wb_addr != 5'd0) begin
            if (i_wb_addr == m.rs1) m.a = i_wb_data;
            if (!m.opimm && i_wb_addr == m.rs2) m.b = i_wb_data;
        end
        if (i_wb_we && i_wb_addr != 5'd0) mrf[i_wb_addr] = i_wb_data;
    endtask

    task automatic check_slot();
        chk("ex_valid", 32'(o_ex_valid), 32'(m.vld));
        chk("opcode",   32'(o_opcode),   32'(m.opc));
        chk("illegal",  32'(o_illegal),  32'(m.ill));
        chk("rd_we",    32'(o_rd_we),    32'(m.we));
        if (m.known) begin
            chk("funct7",   32'(o_funct7),  32'(m.f7));
            chk("funct3",   32'(o_funct3),  32'(m.f3));
            chk("rs1_data", o_rs1_data,     m.a);
            chk("rs2_data", o_rs2_data,     m.b);
            chk("imm",      o_imm,          m.imm);
            chk("rd_addr",  32'(o_rd_addr), 32'(m.rd));
        end
    endtask

    // Called just after a falling edge; ends just after the next falling edge.
    task automatic step(input bit ce, input bit v, input bit [31:0] ins, input bit exr,
                        input bit we, input bit [4:0] wa, input bit [31:0] wd);
        clk_en = ce; i_if_valid = v; i_if_instr = ins; i_ex_ready = exr;
        i_wb_we = we; i_wb_addr = wa; i_wb_data = wd;
        #1;
        chk("if_ready", 32'(o_if_ready), 32'(ce && (!m.vld || exr)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_slot();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_slot();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] ins;
        int        sel;
        ins = $urandom;
        sel = $urandom_range(0, 9);
        ins[19:15] = 5'($urandom_range(0, 7));
        if (sel < 4) begin
            ins[6:0]   = 7'h33;
            ins[24:20] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    ins[31:25] = 7'h00;
                2:       ins[31:25] = 7'h20;
                default: ;
            endcase
        end else if (sel < 8) begin
            ins[6:0] = 7'h13;
            if (ins[13:12] == 2'b01 && $urandom_range(0, 3) != 0)
                ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end else begin
            while (ins[6:0] == 7'h13 || ins[6:0] == 7'h33) ins[6:0] = 7'($urandom);
        end
        return ins;
    endfunction

    localparam bit [31:0] ADDI_X6  = 32'hFFD2_8313;
    localparam bit [31:0] SRAI_X1  = 32'h4041_5093;
    localparam bit [31:0] SLLI_BAD = 32'h4041_1093;
    localparam bit [31:0] SUB_X3   = 32'h4020_81B3;
    localparam bit [31:0] ADD_X4   = 32'h0020_8233;
    localparam bit [31:0] ADD_X8_7 = 32'h0003_8433;
    localparam bit [31:0] ADD_X8_0 = 32'h0000_0433;
    localparam bit [31:0] ADD_X875 = 32'h0053_8433;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clk);
        async_reset();

        // Operand via writeback, then ADDI.
        step(1, 0, 0, 1, 1, 5'd5, 32'h10);
        step(1, 1, ADDI_X6, 1, 0, 0, 0);
        chk("addi_opcode", 32'(o_opcode), 32'h13);
        chk("addi_funct3", 32'(o_funct3), 32'h0);
        chk("addi_rs1",    o_rs1_data,    32'h10);
        chk("addi_imm",    o_imm,         32'hFFFF_FFFD);
        chk("addi_rd",     32'(o_rd_addr), 32'd6);
        chk("addi_we",     32'(o_rd_we),  32'd1);

        step(1, 1, SRAI_X1, 1, 0, 0, 0);
        chk("srai_f7",  32'(o_funct7), 32'h20);
        chk("srai_imm", o_imm,         32'h4);
        step(1, 1, SLLI_BAD, 1, 0, 0, 0);
        chk("slli_ill", 32'(o_illegal), 32'd1);
        chk("slli_opc", 32'(o_opcode),  32'd0);
        chk("slli_we",  32'(o_rd_we),   32'd0);

        // Back-to-back with the ALU always ready.
        step(1, 1, SUB_X3, 1, 0, 0, 0);
        chk("b2b_sub_valid", 32'(o_ex_valid), 32'd1);
        chk("b2b_sub_rd",    32'(o_rd_addr),  32'd3);
        step(1, 1, ADD_X4, 1, 0, 0, 0);
        chk("b2b_add_valid", 32'(o_ex_valid), 32'd1);
        chk("b2b_add_rd",    32'(o_rd_addr),  32'd4);

        // Three-cycle stall, then consume and accept on one edge.
        step(1, 1, SUB_X3, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, ADD_X4, 0, 0, 0, 0);
            chk("stall_ready", 32'(o_if_ready), 32'd0);
            chk("stall_rd",    32'(o_rd_addr),  32'd3);
        end
        step(1, 1, ADD_X4, 1, 0, 0, 0);
        chk("reload_rd", 32'(o_rd_addr), 32'd4);

        // clk_en low freezes everything, including writeback.
        step(0, 1, ADDI_X6, 1, 1, 5'd5, 32'h99);
        chk("ce_low_rd", 32'(o_rd_addr), 32'd4);
        step(1, 1, ADDI_X6, 1, 0, 0, 0);
        chk("ce_low_wb", o_rs1_data, 32'h10);

        // Same-edge writeback into the operand being captured.
        step(1, 0, 0, 1, 1, 5'd7, 32'h1234);
        step(1, 1, ADD_X8_7, 1, 1, 5'd7, 32'hDEAD_BEEF);
        chk("byp_rs1", o_rs1_data, BYP ? 32'hDEAD_BEEF : 32'h1234);
        step(1, 1, ADD_X8_0, 1, 1, 5'd0, 32'h5555_5555);
        chk("x0_rs1", o_rs1_data, 32'h0);

        // Reset asserted mid-stall, register file cleared.
        step(1, 1, ADD_X8_7, 1, 0, 0, 0);
        step(1, 1, ADDI_X6, 0, 0, 0, 0);
        async_reset();
        chk("rst_valid", 32'(o_ex_valid), 32'd0);
        step(1, 1, ADD_X875, 1, 0, 0, 0);
        chk("rst_rf_rs1", o_rs1_data, 32'h0);
        chk("rst_rf_rs2", o_rs2_data, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, rand_instr(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 8)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
